// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode and FSM state enums plus status-flag bit positions
// shared by the sequential ALU and its add/sub datapath.
// Pure type/constant definitions; no logic.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_SHL = 4'd4,
    OP_SHR = 4'd5,
    OP_ROL = 4'd6,
    OP_ROR = 4'd7,
    OP_MUL = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the packed status register
  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/seq_alu_addsub.sv
// seq_alu_addsub: combinational add/subtract at full or half width.
// Zero latency; purely combinational, no handshake.
// In half mode operands are masked to the low half and carry/ovf come from bit HALF-1.
module seq_alu_addsub
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] xm;
  logic [WIDTH-1:0] ym;
  logic [WIDTH:0]   raw;
  logic             sx;
  logic             sy;
  logic             sr;

  // Masked add or subtract; for subtract the carry is the borrow (a < b + cin)
  always_comb begin
    mask  = mode ? {WIDTH{1'b1}} : {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
    xm    = x & mask;
    ym    = y & mask;
    if (sub) raw = {1'b0, xm} - {1'b0, ym} - {{WIDTH{1'b0}}, cin};
    else     raw = {1'b0, xm} + {1'b0, ym} + {{WIDTH{1'b0}}, cin};
    sum   = raw[WIDTH-1:0] & mask;
    carry = mode ? raw[WIDTH] : raw[HALF];
    sx    = mode ? xm[WIDTH-1]  : xm[HALF-1];
    sy    = mode ? ym[WIDTH-1]  : ym[HALF-1];
    sr    = mode ? sum[WIDTH-1] : sum[HALF-1];
    ovf   = sub ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU (add/sub 1 cycle, shift/rotate 1 bit per cycle, optional MUL via SEQ_ALU_MUL_EN).
// Latency: out_valid L+1 cycles after accept (L = 1, max(amt,1) or operating width for MUL).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no accept during DONE.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 20,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_sign,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             err
);

  localparam int HALF = WIDTH / 2;

  function automatic logic [WIDTH-1:0] mask_of(input logic m);
    return m ? {WIDTH{1'b1}} : {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
  endfunction

  function automatic logic msb_of(input logic [WIDTH-1:0] v, input logic m);
    return m ? v[WIDTH-1] : v[HALF-1];
  endfunction

  function automatic logic [WIDTH-1:0] top_bit(input logic m);
    return m ? {1'b1, {(WIDTH-1){1'b0}}} : {{(WIDTH-HALF){1'b0}}, 1'b1, {(HALF-1){1'b0}}};
  endfunction

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         op_q;
  logic               mode_q;
  logic [WIDTH-1:0]   a_q;      // shift work register / multiplier low half
  logic [WIDTH-1:0]   b_q;
  logic               amt_zero_q;
  logic [3:0]         flags;

  // Accept-side decode: clamped shift amount and step count
  logic [SHAMT_W-1:0] wop_in;
  logic [SHAMT_W-1:0] amt_in;
  logic [SHAMT_W-1:0] len_in;

  // Compute the number of RUN steps for the incoming operation
  always_comb begin
    wop_in = mode ? SHAMT_W'(WIDTH) : SHAMT_W'(HALF);
    amt_in = (b[SHAMT_W-1:0] > wop_in) ? wop_in : b[SHAMT_W-1:0];
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: len_in = (amt_in == '0) ? SHAMT_W'(1) : amt_in;
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:                         len_in = wop_in;
`endif
      default:                        len_in = SHAMT_W'(1);
    endcase
  end

  // Shared adder: arithmetic ops, or the multiply accumulate step
  logic [WIDTH-1:0] as_x, as_y, as_sum;
  logic             as_cin, as_sub, as_carry, as_ovf;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] result_hi_q;
  logic [WIDTH-1:0] mul_lo_nxt;
  logic [WIDTH-1:0] mul_hi_nxt;
`endif

  // Select adder operands; MUL adds b into the high accumulator when the multiplier LSB is set
  always_comb begin
    as_x   = a_q;
    as_y   = b_q;
    as_sub = (op_q == OP_SUB) || (op_q == OP_SBC);
    as_cin = ((op_q == OP_ADC) || (op_q == OP_SBC)) ? flags[FLAG_C] : 1'b0;
`ifdef SEQ_ALU_MUL_EN
    if (op_q == OP_MUL) begin
      as_x   = hi_q;
      as_y   = a_q[0] ? b_q : '0;
      as_sub = 1'b0;
      as_cin = 1'b0;
    end
`endif
  end

  seq_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x     (as_x),
    .y     (as_y),
    .cin   (as_cin),
    .sub   (as_sub),
    .mode  (mode_q),
    .sum   (as_sum),
    .carry (as_carry),
    .ovf   (as_ovf)
  );

`ifdef SEQ_ALU_MUL_EN
  // Right-shift {carry, acc_hi, multiplier} by one bit at the operating width
  always_comb begin
    mul_hi_nxt = (as_sum >> 1) | (as_carry  ? top_bit(mode_q) : '0);
    mul_lo_nxt = (a_q >> 1)    | (as_sum[0] ? top_bit(mode_q) : '0);
  end
`endif

  // One shift/rotate step and the bit that falls out
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_cout;

  always_comb begin
    sh_nxt  = a_q;
    sh_cout = 1'b0;
    case (op_q)
      OP_SHL: begin
        sh_cout = msb_of(a_q, mode_q);
        sh_nxt  = (a_q << 1) & mask_of(mode_q);
      end
      OP_SHR: begin
        sh_cout = a_q[0];
        sh_nxt  = a_q >> 1;
      end
      OP_ROL: begin
        sh_cout = msb_of(a_q, mode_q);
        sh_nxt  = ((a_q << 1) | {{(WIDTH-1){1'b0}}, msb_of(a_q, mode_q)}) & mask_of(mode_q);
      end
      OP_ROR: begin
        sh_cout = a_q[0];
        sh_nxt  = (a_q >> 1) | (a_q[0] ? top_bit(mode_q) : '0);
      end
      default: ;
    endcase
    if (amt_zero_q) begin
      sh_nxt  = a_q;
      sh_cout = 1'b0;
    end
  end

  // Final-step result, error and next status register
  logic [WIDTH-1:0] fin_res;
  logic [WIDTH-1:0] fin_hi;
  logic             fin_c, fin_v, fin_err;
  logic [3:0]       fin_flags;

  always_comb begin
    fin_res = '0;
    fin_hi  = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_err = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        fin_res = as_sum;
        fin_c   = as_carry;
        fin_v   = as_ovf;
      end
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
        fin_res = sh_nxt;
        fin_c   = sh_cout;
      end
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: begin
        fin_res = mul_lo_nxt;
        fin_hi  = mul_hi_nxt;
        fin_c   = |mul_hi_nxt;
      end
`endif
      default: fin_err = 1'b1;
    endcase
    fin_flags = flags;
    if (!fin_err) begin
      fin_flags[FLAG_Z] = (fin_res == '0);
      fin_flags[FLAG_S] = msb_of(fin_res, mode_q);
      fin_flags[FLAG_C] = fin_c;
      fin_flags[FLAG_V] = fin_v;
    end
  end

  // Control FSM with registered handshake, result and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      mode_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      amt_zero_q <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      err        <= 1'b0;
      flags      <= '0;
`ifdef SEQ_ALU_MUL_EN
      hi_q        <= '0;
      result_hi_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q       <= op;
            mode_q     <= mode;
            a_q        <= a & mask_of(mode);
            b_q        <= b & mask_of(mode);
            amt_zero_q <= (amt_in == '0);
            cnt        <= len_in;
            in_ready   <= 1'b0;
            state      <= RUN;
`ifdef SEQ_ALU_MUL_EN
            hi_q       <= '0;
`endif
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
`ifdef SEQ_ALU_MUL_EN
          if (op_q == OP_MUL) begin
            a_q  <= mul_lo_nxt;
            hi_q <= mul_hi_nxt;
          end else begin
            a_q  <= sh_nxt;
          end
`else
          a_q <= sh_nxt;
`endif
          if (cnt == SHAMT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= fin_res;
            err       <= fin_err;
            flags     <= fin_flags;
`ifdef SEQ_ALU_MUL_EN
            result_hi_q <= fin_hi;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_ALU_MUL_EN
  assign result_hi = result_hi_q;
`else
  assign result_hi = '0;
  logic unused_fin_hi;
  assign unused_fin_hi = |fin_hi;
`endif

  assign flag_zero  = flags[FLAG_Z];
  assign flag_sign  = flags[FLAG_S];
  assign flag_carry = flags[FLAG_C];
  assign flag_ovf   = flags[FLAG_V];

endmodule
